// File: rtl/fir_tap_sequencer_if.sv
// Bus between the FIR tap sequencer and its surroundings: the input sample
// stream plus the sample-RAM, coefficient-ROM and MAC control lines.
//   master : the sequencer (accepts samples, drives RAM/ROM/MAC controls)
//   slave  : the sample source / datapath side
// Signals:
//   in_valid, in_data, in_ready       sample stream handshake
//   ram_we, ram_wr_addr, ram_wr_din   sample RAM write port
//   ram_rd_addr                       sample RAM read port (1-cycle latency)
//   coef_addr                         coefficient ROM address (1-cycle latency)
//   mac_clr, mac_en, mac_last         MAC strobes
//   out_valid                         MAC accumulator holds a finished output
interface fir_tap_sequencer_if #(
  parameter int N = 8,
  parameter int M = 32
);
  localparam int AW = $clog2(M);

  logic          in_valid;
  logic [N-1:0]  in_data;
  logic          in_ready;
  logic          ram_we;
  logic [AW-1:0] ram_wr_addr;
  logic [N-1:0]  ram_wr_din;
  logic [AW-1:0] ram_rd_addr;
  logic [AW-1:0] coef_addr;
  logic          mac_clr;
  logic          mac_en;
  logic          mac_last;
  logic          out_valid;

  modport master (
    input  in_valid, in_data,
    output in_ready, ram_we, ram_wr_addr, ram_wr_din, ram_rd_addr,
           coef_addr, mac_clr, mac_en, mac_last, out_valid
  );

  modport slave (
    output in_valid, in_data,
    input  in_ready, ram_we, ram_wr_addr, ram_wr_din, ram_rd_addr,
           coef_addr, mac_clr, mac_en, mac_last, out_valid
  );
endinterface

// File: rtl/fir_tap_sequencer.sv
// FIR tap sequencer. Keeps the sample delay line as a circular buffer in a
// dual-port RAM, clears it after reset, stores each accepted sample at the
// write pointer and then walks all M taps (newest sample with coefficient 0,
// oldest with coefficient M-1), driving the MAC strobes and flagging the
// finished output. One sample is processed every M+4 cycles.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset; aborts any operation and reruns CLEAR
//   bus  fir_tap_sequencer_if.master (sample stream, RAM/ROM/MAC controls)
module fir_tap_sequencer #(
  parameter int N = 8,
  parameter int M = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  fir_tap_sequencer_if.master  bus
);
  localparam int AW = $clog2(M);
  localparam logic [AW-1:0] K_LAST = AW'(M - 1);
  localparam logic [AW:0]   M_EXT  = (AW + 1)'(M);

  typedef enum logic [2:0] {
    S_CLEAR,
    S_IDLE,
    S_WRITE,
    S_READ,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] wp_q, wp_d;
  logic [AW-1:0] k_q, k_d;
  logic [N-1:0]  samp_q, samp_d;
  logic          en_q, en_d;
  logic          clr_q, clr_d;
  logic          last_q, last_d;
  // Address/data outputs keep their last driven value when unused.
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [N-1:0]  din_q, din_d;
  logic [AW-1:0] rd_addr_q, rd_addr_d;
  logic [AW-1:0] coef_q, coef_d;

  logic [AW:0]   rd_wrap;
  logic [AW-1:0] rd_tap;
  logic          ready_c, we_c, ov_c;

  // (wp - k) mod M without assuming M is a power of two.
  always_comb begin
    rd_wrap = {1'b0, wp_q} + M_EXT - {1'b0, k_q};
    rd_tap  = (wp_q >= k_q) ? (wp_q - k_q) : rd_wrap[AW-1:0];
  end

  always_comb begin
    state_d   = state_q;
    wp_d      = wp_q;
    k_d       = k_q;
    samp_d    = samp_q;
    wr_addr_d = wr_addr_q;
    din_d     = din_q;
    rd_addr_d = rd_addr_q;
    coef_d    = coef_q;
    en_d      = 1'b0;
    clr_d     = 1'b0;
    last_d    = 1'b0;
    ready_c   = 1'b0;
    we_c      = 1'b0;
    ov_c      = 1'b0;
    unique case (state_q)
      S_CLEAR: begin
        we_c      = 1'b1;
        wr_addr_d = k_q;
        din_d     = '0;
        if (k_q == K_LAST) begin
          k_d     = '0;
          state_d = S_IDLE;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      S_IDLE: begin
        ready_c = 1'b1;
        if (bus.in_valid) begin
          samp_d  = bus.in_data;
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        we_c      = 1'b1;
        wr_addr_d = wp_q;
        din_d     = samp_q;
        k_d       = '0;
        state_d   = S_READ;
      end
      S_READ: begin
        rd_addr_d = rd_tap;
        coef_d    = k_q;
        // Strobes are registered so they line up with the 1-cycle RAM/ROM data.
        en_d      = 1'b1;
        clr_d     = (k_q == '0);
        last_d    = (k_q == K_LAST);
        if (k_q == K_LAST) begin
          state_d = S_DRAIN;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      S_DRAIN: begin
        state_d = S_DONE;
      end
      S_DONE: begin
        ov_c    = 1'b1;
        wp_d    = (wp_q == K_LAST) ? '0 : wp_q + 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_CLEAR;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_CLEAR;
      wp_q      <= '0;
      k_q       <= '0;
      samp_q    <= '0;
      en_q      <= 1'b0;
      clr_q     <= 1'b0;
      last_q    <= 1'b0;
      wr_addr_q <= '0;
      din_q     <= '0;
      rd_addr_q <= '0;
      coef_q    <= '0;
    end else begin
      state_q   <= state_d;
      wp_q      <= wp_d;
      k_q       <= k_d;
      samp_q    <= samp_d;
      en_q      <= en_d;
      clr_q     <= clr_d;
      last_q    <= last_d;
      wr_addr_q <= wr_addr_d;
      din_q     <= din_d;
      rd_addr_q <= rd_addr_d;
      coef_q    <= coef_d;
    end
  end

  // Control outputs are forced low for the whole time rst is high, not only
  // from the cycle after the first reset edge.
  assign bus.in_ready    = ready_c & ~rst;
  assign bus.ram_we      = we_c & ~rst;
  assign bus.out_valid   = ov_c & ~rst;
  assign bus.mac_en      = en_q & ~rst;
  assign bus.mac_clr     = clr_q & ~rst;
  assign bus.mac_last    = last_q & ~rst;
  assign bus.ram_wr_addr = wr_addr_d;
  assign bus.ram_wr_din  = din_d;
  assign bus.ram_rd_addr = rd_addr_d;
  assign bus.coef_addr   = coef_d;
endmodule

// File: tb/tb_fir_tap_sequencer.sv
// Self-checking bench for fir_tap_sequencer: an M=32 instance with a
// behavioural RAM/ROM/MAC datapath and an FIR reference model, and an M=5
// instance for non-power-of-two address wrap.
module tb_fir_tap_sequencer;
  localparam int N  = 8;
  localparam int M  = 32;
  localparam int M5 = 5;

  logic clk;
  logic rst;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  fir_tap_sequencer_if #(.N(N), .M(M))  b32 ();
  fir_tap_sequencer_if #(.N(N), .M(M5)) b5 ();

  fir_tap_sequencer #(.N(N), .M(M))  u32 (.clk(clk), .rst(rst), .bus(b32));
  fir_tap_sequencer #(.N(N), .M(M5)) u5  (.clk(clk), .rst(rst), .bus(b5));

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Datapath around the M=32 instance: sample RAM, ROM with h[i]=i+1, MAC.
  logic [N-1:0] ram32 [M];
  logic [N-1:0] rd32;
  logic [31:0]  cf32;
  logic [31:0]  acc32;

  initial for (int i = 0; i < M; i++) ram32[i] = 8'hA5;

  always @(posedge clk) begin
    if (b32.ram_we) ram32[b32.ram_wr_addr] <= b32.ram_wr_din;
    rd32 <= ram32[b32.ram_rd_addr];
    cf32 <= 32'(b32.coef_addr) + 32'd1;
    if (b32.mac_en) acc32 <= b32.mac_clr ? 32'(rd32) * cf32 : acc32 + 32'(rd32) * cf32;
  end

  // Monitors.
  int unsigned ov32_cnt = 0;
  int unsigned bad_addr = 0;
  always @(negedge clk) begin
    if (!rst) begin
      if (b32.out_valid) ov32_cnt++;
      if (32'(b32.ram_wr_addr) >= M || 32'(b32.ram_rd_addr) >= M || 32'(b32.coef_addr) >= M)
        bad_addr++;
      if (32'(b5.ram_wr_addr) >= M5 || 32'(b5.ram_rd_addr) >= M5 || 32'(b5.coef_addr) >= M5)
        bad_addr++;
    end
  end

  // Reference model: hist32[i] is the i-th newest accepted sample.
  logic [N-1:0] hist32 [M];
  int wp32_m;
  int wp5_m;

  task automatic model_reset();
    for (int i = 0; i < M; i++) hist32[i] = '0;
    wp32_m = 0;
    wp5_m  = 0;
  endtask

  task automatic model_push(input logic [N-1:0] d);
    for (int i = M - 1; i > 0; i--) hist32[i] = hist32[i-1];
    hist32[0] = d;
  endtask

  function automatic logic [31:0] fir_ref();
    logic [31:0] s;
    s = '0;
    for (int i = 0; i < M; i++) s = s + 32'(hist32[i]) * 32'(i + 1);
    return s;
  endfunction

  task automatic do_reset();
    int we_n = 0;
    int addr_bad = 0;
    int rdy_c = 0;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst_in_ready", b32.in_ready, 0);
    chk("rst_ram_we", b32.ram_we, 0);
    chk("rst_strobes", {b32.mac_en, b32.mac_clr, b32.mac_last, b32.out_valid}, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    for (int c = 1; c <= M + 1; c++) begin
      @(negedge clk);
      if (b32.ram_we) begin
        we_n++;
        if (32'(b32.ram_wr_addr) != c - 1 || b32.ram_wr_din != '0) addr_bad++;
      end
      if (b32.in_ready && rdy_c == 0) rdy_c = c;
    end
    chk("clear_we_count", we_n, M);
    chk("clear_addr_data", addr_bad, 0);
    chk("clear_ready_rise", rdy_c, M + 1);
  endtask

  task automatic send32(input logic [N-1:0] d, input bit hold, output logic [31:0] y);
    int w = 0;
    int we_n = 0, en_n = 0, clr_n = 0, last_n = 0, ov_n = 0;
    int en_first = 0, clr_c = 0, last_c = 0, ov_c = 0, rdy_c = 0;
    logic [31:0] wa, wd, y_exp;
    wa = '0;
    wd = '0;
    y  = '0;
    while (!b32.in_ready && w < 400) begin
      @(negedge clk);
      w++;
    end
    if (!b32.in_ready) begin
      n_vec++;
      n_bad++;
      $display("FAIL send32_ready_timeout: in_ready=0 after %0d cycles, required 1", w);
      return;
    end
    b32.in_valid = 1'b1;
    b32.in_data  = d;
    @(posedge clk);
    #1;
    if (!hold) b32.in_valid = 1'b0;
    b32.in_data = ~d;
    model_push(d);
    y_exp = fir_ref();
    for (int c = 1; c <= M + 4; c++) begin
      @(negedge clk);
      if (b32.ram_we) begin
        we_n++;
        wa = 32'(b32.ram_wr_addr);
        wd = 32'(b32.ram_wr_din);
      end
      if (b32.mac_en) begin
        en_n++;
        if (en_first == 0) en_first = c;
      end
      if (b32.mac_clr)  begin clr_n++;  clr_c  = c; end
      if (b32.mac_last) begin last_n++; last_c = c; end
      if (b32.out_valid) begin ov_n++; ov_c = c; y = acc32; end
      if (b32.in_ready && rdy_c == 0) rdy_c = c;
    end
    chk("wr_count", we_n, 1);
    chk("wr_addr", wa, wp32_m);
    chk("wr_data", wd, d);
    chk("mac_en_count", en_n, M);
    chk("mac_en_first", en_first, 3);
    chk("mac_clr_count", clr_n, 1);
    chk("mac_clr_cycle", clr_c, 3);
    chk("mac_last_count", last_n, 1);
    chk("mac_last_cycle", last_c, M + 2);
    chk("out_valid_count", ov_n, 1);
    chk("out_valid_cycle", ov_c, M + 3);
    chk("in_ready_cycle", rdy_c, M + 4);
    chk("fir_output", y, y_exp);
    wp32_m = (wp32_m + 1) % M;
  endtask

  task automatic send5(input logic [N-1:0] d, output logic [31:0] wa, output logic [31:0] seq);
    int w = 0;
    int rd_bad = 0, en_n = 0, ov_c = 0;
    logic we1;
    wa  = '0;
    seq = '0;
    we1 = 1'b0;
    while (!b5.in_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (!b5.in_ready) begin
      n_vec++;
      n_bad++;
      $display("FAIL send5_ready_timeout: in_ready=0 after %0d cycles, required 1", w);
      return;
    end
    b5.in_valid = 1'b1;
    b5.in_data  = d;
    @(posedge clk);
    #1 b5.in_valid = 1'b0;
    for (int c = 1; c <= M5 + 4; c++) begin
      @(negedge clk);
      if (c == 1) begin
        wa  = 32'(b5.ram_wr_addr);
        we1 = b5.ram_we;
      end
      if (c >= 2 && c <= M5 + 1) begin
        seq = {seq[27:0], 4'(b5.ram_rd_addr)};
        if (32'(b5.ram_rd_addr) != (wp5_m + M5 - (c - 2)) % M5 || 32'(b5.coef_addr) != c - 2)
          rd_bad++;
      end
      if (b5.mac_en) en_n++;
      if (b5.out_valid && ov_c == 0) ov_c = c;
    end
    chk("m5_we", we1, 1);
    chk("m5_rd_addr", rd_bad, 0);
    chk("m5_en_count", en_n, M5);
    chk("m5_ov_cycle", ov_c, M5 + 3);
    wp5_m = (wp5_m + 1) % M5;
  endtask

  typedef struct {
    logic [N-1:0] din;
    logic [31:0]  y_exp;
  } vec_t;

  vec_t imp_tab [M + 1];
  int   m5_wa_tab [7];

  initial begin
    logic [31:0] y;
    logic [31:0] wa;
    logic [31:0] seq;
    int unsigned ov_before;

    // Impulse response with h[i]=i+1: 0x7F*(j+1), then zero once it leaves.
    for (int j = 0; j < M; j++) begin
      imp_tab[j].din   = (j == 0) ? 8'h7F : 8'h00;
      imp_tab[j].y_exp = 32'h7F * 32'(j + 1);
    end
    imp_tab[M].din   = 8'h00;
    imp_tab[M].y_exp = 32'd0;
    m5_wa_tab = '{0, 1, 2, 3, 4, 0, 1};

    b32.in_valid = 1'b0;
    b32.in_data  = '0;
    b5.in_valid  = 1'b0;
    b5.in_data   = '0;
    rst = 1'b1;

    do_reset();

    for (int j = 0; j <= M; j++) begin
      send32(imp_tab[j].din, 1'b0, y);
      chk("impulse_table", y, imp_tab[j].y_exp);
    end

    // Back-to-back with in_valid held high the whole time.
    for (int s = 0; s < 3; s++) send32(8'($urandom), 1'b1, y);
    b32.in_valid = 1'b0;

    // Randomized samples, holds and idle gaps.
    for (int s = 0; s < 40; s++) begin
      bit hold;
      hold = 1'($urandom_range(0, 1));
      send32(8'($urandom), hold, y);
      if (hold) b32.in_valid = 1'b0;
      else repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    // Abort in READ at k=10 (cycle 12 after the handshake).
    b32.in_valid = 1'b1;
    b32.in_data  = 8'h55;
    @(posedge clk);
    #1 b32.in_valid = 1'b0;
    repeat (12) @(negedge clk);
    chk("abort_rd_addr", b32.ram_rd_addr, (wp32_m + M - 10) % M);
    chk("abort_coef_addr", b32.coef_addr, 10);
    ov_before = ov32_cnt;
    do_reset();
    repeat (5) @(negedge clk);
    chk("abort_no_out_valid", ov32_cnt - ov_before, 0);
    send32(8'h3C, 1'b0, y);

    // Full-scale: buffer filled with 0xFF.
    do_reset();
    for (int j = 0; j < M; j++) send32(8'hFF, 1'b0, y);
    chk("fullscale_y", y, 32'd134640);

    // Non-power-of-two wrap on the M=5 instance (reset by the last do_reset).
    for (int j = 0; j < 7; j++) begin
      send5(8'(j + 1), wa, seq);
      chk("m5_wr_addr_table", wa, m5_wa_tab[j]);
    end
    chk("m5_7th_read_order", seq[19:0], 20'h10432);

    chk("addr_in_range", bad_addr, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    n_bad++;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
